// File: rtl/mult_issue_ctrl.sv
// Operand-issue / result-capture controller in front of a sequential multiplier.
// Optional watchdog: define MULT_ISSUE_TIMEOUT_EN to enable the TIMEOUT_CYC abort path.
module mult_issue_ctrl #(
  parameter int DP_WIDTH    = 5,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DP_WIDTH-1:0]   in_a,
  input  logic [DP_WIDTH-1:0]   in_b,
  output logic                  mult_start,
  output logic [DP_WIDTH-1:0]   mult_multiplicand,
  output logic [DP_WIDTH-1:0]   mult_multiplier,
  input  logic                  mult_rdy,
  input  logic [2*DP_WIDTH-1:0] mult_product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DP_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_DONE, S_OUT
  } state_e;

  state_e                state_q, state_d;
  logic [DP_WIDTH-1:0]   opa_q, opa_d;
  logic [DP_WIDTH-1:0]   opb_q, opb_d;
  logic [2*DP_WIDTH-1:0] data_q, data_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [TAG_W-1:0]      job_q, job_d;
  logic                  in_ready_c;
  logic                  timeout;
  logic                  waiting;

  assign waiting = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_DONE);

`ifdef MULT_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Counter holds the number of cycles already spent in the wait states.
  assign timeout = waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_ISSUE)  wd_d = '0;
    else if (waiting)        wd_d = wd_q + 1'b1;
    if (timeout)             err_d = 1'b1;
    else if ((state_q == S_OUT) && out_ready) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    data_d     = data_q;
    tag_d      = tag_q;
    job_d      = job_q;
    in_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = mult_rdy;
        if (in_valid && mult_rdy) begin
          opa_d   = in_a;
          opb_d   = in_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (timeout) begin
          data_d  = '0;
          tag_d   = job_q;
          state_d = S_OUT;
        end else if (!mult_rdy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (timeout) begin
          data_d  = '0;
          tag_d   = job_q;
          state_d = S_OUT;
        end else if (mult_rdy) begin
          data_d  = mult_product;
          tag_d   = job_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          job_d   = job_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      job_q   <= job_d;
    end
  end

  // in_ready follows mult_rdy combinationally, so mask it while reset is held.
  assign in_ready          = in_ready_c & ~rst;
  assign mult_start        = (state_q == S_ISSUE);
  assign mult_multiplicand = opa_q;
  assign mult_multiplier   = opb_q;
  assign out_valid         = (state_q == S_OUT);
  assign out_data          = data_q;
  assign out_tag           = tag_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: behavioural multiplier model plus
// an expected-result scoreboard filled at each input handshake.
module tb_mult_issue_ctrl;

  localparam int DW = 5;
  localparam int TW = 4;

  typedef struct packed {
    logic [2*DW-1:0] data;
    logic [TW-1:0]   tag;
    logic            err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic            mult_start;
  logic [DW-1:0]   mult_multiplicand;
  logic [DW-1:0]   mult_multiplier;
  logic            m_rdy;
  logic [2*DW-1:0] m_prod;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] out_data;
  logic [TW-1:0]   out_tag;
  logic            out_err;
  logic            busy;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  logic [TW-1:0] exp_tag = '0;
  int          lat_cfg = 4;
  bit          stuck = 1'b0;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.DP_WIDTH(DW), .TAG_W(TW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_start(mult_start), .mult_multiplicand(mult_multiplicand),
    .mult_multiplier(mult_multiplier), .mult_rdy(m_rdy), .mult_product(m_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  // Behavioural sequential multiplier: idle with rdy high; start drops rdy for
  // lat_cfg+1 cycles with junk on the product bus, then presents a*b.
  logic [DW-1:0] m_a, m_b;
  int            m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy <= 1'b1; m_prod <= '0; m_a <= '0; m_b <= '0; m_cnt <= 0;
    end else if (m_rdy) begin
      if (mult_start) begin
        m_rdy <= 1'b0; m_a <= mult_multiplicand; m_b <= mult_multiplier; m_cnt <= lat_cfg;
      end
    end else begin
      m_prod <= 10'($urandom);
      if (!stuck) begin
        if (m_cnt == 0) begin
          m_rdy  <= 1'b1;
          m_prod <= {5'd0, m_a} * {5'd0, m_b};
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic do_job(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int hold, input bit scramble, input bit expect_err);
    exp_t e;
    int n, starts;
    bit inflight_ok, bp_ok;
    logic [2*DW-1:0] d0;
    logic [TW-1:0] t0;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait a=%0d b=%0d in_ready=%b required=1", a, b, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.data = expect_err ? '0 : ({5'd0, a} * {5'd0, b});
    e.tag  = exp_tag;
    e.err  = expect_err;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = scramble;
    starts = 0; inflight_ok = 1'b1; n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (mult_start === 1'b1) starts++;
      if (mult_multiplicand !== a || mult_multiplier !== b || in_ready !== 1'b0) inflight_ok = 1'b0;
      if (scramble) begin in_a = 5'($urandom); in_b = 5'($urandom); end
      @(negedge clk); n++;
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_wait a=%0d b=%0d out_valid=%b required=1", a, b, out_valid);
      return;
    end
    checks++;
    if (starts != 1) begin
      failures++; $display("FAIL start_pulses a=%0d b=%0d got=%0d required=1", a, b, starts);
    end
    checks++;
    if (!inflight_ok || mult_multiplicand !== a || mult_multiplier !== b) begin
      failures++;
      $display("FAIL operand_hold a=%0d b=%0d got=%0d,%0d required=%0d,%0d",
               a, b, mult_multiplicand, mult_multiplier, a, b);
    end
    checks++;
    if (out_data !== e.data) begin
      failures++; $display("FAIL out_data a=%0d b=%0d got=%0d required=%0d", a, b, out_data, e.data);
    end
    checks++;
    if (out_tag !== e.tag) begin
      failures++; $display("FAIL out_tag a=%0d b=%0d got=%0d required=%0d", a, b, out_tag, e.tag);
    end
    checks++;
    if (out_err !== e.err) begin
      failures++; $display("FAIL out_err a=%0d b=%0d got=%b required=%b", a, b, out_err, e.err);
    end
    d0 = out_data; t0 = out_tag; bp_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_tag !== t0 ||
          in_ready !== 1'b0 || mult_start !== 1'b0) bp_ok = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!bp_ok) begin
        failures++;
        $display("FAIL backpressure_hold data=%0d tag=%0d required data=%0d tag=%0d stable",
                 out_data, out_tag, d0, t0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL handshake_clear out_valid=%b busy=%b required=0,0", out_valid, busy);
    end
    exp_tag++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid,
         out_data, out_tag, out_err, busy} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs in_ready=%b start=%b data=%0d tag=%0d valid=%b busy=%b required all 0",
               in_ready, mult_start, out_data, out_tag, out_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset in_ready=%b busy=%b required=1,0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    lat_cfg = 5;
    do_job(5'd7, 5'd9, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    lat_cfg = 3;
    do_job(5'd21, 5'd13, 20, 1'b1, 1'b0);
  endtask

  task automatic test_sweep;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        lat_cfg = $urandom_range(0, 3);
        do_job(5'(a), 5'(b), 0, (a == b), 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    int n;
    lat_cfg = 6;
    @(negedge clk);
    in_a = 5'd3; in_b = 5'd4; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || m_rdy !== 1'b0) begin
      failures++; $display("FAIL mid_job_busy busy=%b mult_rdy=%b required=1,0", busy, m_rdy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, mult_start, mult_multiplicand, mult_multiplier, out_valid,
         out_data, out_tag, out_err, busy} !== 29'd0) begin
      failures++;
      $display("FAIL async_reset_outputs busy=%b a=%0d b=%0d tag=%0d data=%0d required all 0",
               busy, mult_multiplicand, mult_multiplier, out_tag, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_tag = '0;
    do_job(5'd5, 5'd6, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int n;
    stuck = 1'b1;
`ifdef MULT_ISSUE_TIMEOUT_EN
    do_job(5'd9, 5'd3, 0, 1'b0, 1'b1);
`else
    @(negedge clk);
    in_a = 5'd9; in_b = 5'd3; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stuck_wait busy=%b out_valid=%b required=1,0", busy, out_valid);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stuck = 1'b0;
    exp_tag = '0;
    lat_cfg = 2;
    do_job(5'd31, 5'd31, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sweep();
    test_reset_mid_job();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
